ham_secded_dec_pipe: RTL and testbench
======================================

HAM_SECDED_DEC_PIPE -- requirements
Module: ham_secded_dec_pipe

Interface
REQ-001 Parameter DATA_BITS, default 4: data bits per codeword.
REQ-002 Parameter NUM_CH, default 2: number of codeword lanes decoded in parallel per beat.
REQ-003 Localparam PAR_BITS: smallest P with 2^P >= DATA_BITS+P+1 (P=3 for DATA_BITS=4).
REQ-004 Localparam CW_BITS = DATA_BITS+PAR_BITS+1 (8 for defaults); position CW_BITS is the overall even-parity bit.
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_valid  input  1  beat on i_data is valid.
REQ-008 o_ready  output  1  block accepts a beat this cycle.
REQ-009 i_data  input  NUM_CH*CW_BITS  codewords; lane c, position j (1..CW_BITS) at bit c*CW_BITS+j-1.
REQ-010 o_valid  output  1  o_dout and flags valid.
REQ-011 i_ready  input  1  downstream accepts output beat.
REQ-012 o_dout  output  NUM_CH*DATA_BITS  corrected data; lane c at [c*DATA_BITS +: DATA_BITS], non-power-of-2 positions in ascending order, lowest first.
REQ-013 o_sbit_err  output  NUM_CH  per-lane single-bit error corrected.
REQ-014 o_dbit_err  output  NUM_CH  per-lane uncorrectable error.

Function
REQ-015 Per lane: syndrome S = XOR of indices j in 1..CW_BITS-1 whose bit is 1; overall parity p = XOR of all CW_BITS bits.
REQ-016 S=0,p=0: no error; data passed, both flags 0.
REQ-017 p=1, 1<=S<=CW_BITS-1: flip position S, o_sbit_err=1.
REQ-018 p=1, S=0: overall parity bit in error; data unchanged, o_sbit_err=1.
REQ-019 S!=0, p=0: double error; data passed uncorrected, o_dbit_err=1.
REQ-020 p=1, S>CW_BITS-1 (non-existent position): no flip, o_dbit_err=1, o_sbit_err=0.
REQ-021 o_sbit_err and o_dbit_err are never both 1 in the same lane.
REQ-022 Two-stage pipeline: stage 1 registers input codewords, S and p; stage 2 registers corrected data and flags; latency 2 cycles accept-to-o_valid with i_ready held 1.
REQ-023 Advance = !o_valid || i_ready; o_ready = advance; both stages load only when advance=1.
REQ-024 Beat accepted when i_valid && o_ready; one beat per cycle throughput with no backpressure.
REQ-025 o_valid && !i_ready: o_dout, flags, o_valid and stage-1 contents hold unchanged; no beat lost or duplicated.
REQ-026 Stage valid bits propagate bubbles: i_valid=0 on an advancing cycle inserts a bubble.
REQ-027 Lanes decode independently; an error in one lane never alters another lane's data or flags.

Reset
REQ-028 i_rst_n=0 immediately clears both stage valid bits, o_valid=0, o_dout=0, o_sbit_err=0, o_dbit_err=0, counters=0.
REQ-029 Reset mid-operation discards in-flight beats; o_ready=1 in the first cycle after deassertion.

Configuration
REQ-030 Macro HAM_ERR_CNT_EN defined: adds ports i_cnt_clr (input, 1), o_sbit_cnt (output, 16), o_dbit_cnt (output, 16).
REQ-031 With HAM_ERR_CNT_EN: on each output handshake (o_valid && i_ready), counters add the popcount of o_sbit_err / o_dbit_err, saturating at 16'hFFFF.
REQ-032 With HAM_ERR_CNT_EN: i_cnt_clr=1 zeroes both counters next edge and overrides a simultaneous increment.
REQ-033 Without HAM_ERR_CNT_EN: those ports and counters are absent; all other behaviour identical.

Verification
REQ-034 Defaults, lane0 = clean encoding of 4'b1011, i_ready=1 -> o_valid 2 cycles later, lane0 dout=4'b1011, flags 0.
REQ-035 Lane1 clean word with position 5 flipped -> lane1 dout = original, o_sbit_err=2'b10, o_dbit_err=0.
REQ-036 Lane0 positions 3 and 6 flipped -> o_dbit_err[0]=1, data uncorrected; lane0 with only position 8 flipped -> o_sbit_err[0]=1, data intact.
REQ-037 Stream 4 beats, i_ready=0 for 3 cycles mid-stream -> o_ready=0 while output stalled; all 4 beats emerge in order, none lost.
REQ-038 Assert i_rst_n=0 with 2 beats in flight -> o_valid=0 asynchronously; no stale beat after release.
REQ-039 HAM_ERR_CNT_EN: 3 beats each with 2 single-error lanes -> o_sbit_cnt=6; preload near 16'hFFFF -> saturates; i_cnt_clr -> 0.

Source files
------------

// File: rtl/ham_secded_dec_pipe_if.sv
// ham_secded_dec_pipe_if
// Streaming bus for the SECDED decoder pipeline.
//   i_valid / o_ready : upstream handshake, i_data carries NUM_CH codewords
//   o_valid / i_ready : downstream handshake, o_dout carries corrected data
//   o_sbit_err        : per-lane corrected single-bit error
//   o_dbit_err        : per-lane uncorrectable error
// Modports: slave = decoder side, master = producer/consumer side.
interface ham_secded_dec_pipe_if #(
    parameter int DATA_BITS = 4,
    parameter int NUM_CH    = 2
);
    // Smallest P with 2^P >= DATA_BITS + P + 1.
    function automatic int calc_par_bits(input int d);
        int p;
        p = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << p) < (d + p + 1)) begin
                p = p + 1;
            end
        end
        return p;
    endfunction

    localparam int PAR_BITS = calc_par_bits(DATA_BITS);
    localparam int CW_BITS  = DATA_BITS + PAR_BITS + 1;

    logic                          i_valid;
    logic                          o_ready;
    logic [NUM_CH*CW_BITS-1:0]     i_data;
    logic                          o_valid;
    logic                          i_ready;
    logic [NUM_CH*DATA_BITS-1:0]   o_dout;
    logic [NUM_CH-1:0]             o_sbit_err;
    logic [NUM_CH-1:0]             o_dbit_err;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_dout, o_sbit_err, o_dbit_err
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_dout, o_sbit_err, o_dbit_err
    );
endinterface

// File: rtl/ham_secded_dec_pipe.sv
// ham_secded_dec_pipe
// Two-stage pipelined extended-Hamming (SECDED) decoder, NUM_CH lanes per beat.
//   Stage 1 captures the codewords with their syndromes and overall parity.
//   Stage 2 corrects, extracts data bits and raises the error flags.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : valid/ready stream in, valid/ready stream out (see _if)
// Optional feature (macro HAM_ERR_CNT_EN):
//   i_cnt_clr      : synchronous clear of both error counters
//   o_sbit_cnt     : saturating count of corrected lanes
//   o_dbit_cnt     : saturating count of uncorrectable lanes
module ham_secded_dec_pipe #(
    parameter int DATA_BITS = 4,
    parameter int NUM_CH    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
`ifdef HAM_ERR_CNT_EN
    input  logic                  i_cnt_clr,
    output logic [15:0]           o_sbit_cnt,
    output logic [15:0]           o_dbit_cnt,
`endif
    ham_secded_dec_pipe_if.slave  bus
);

    function automatic int calc_par_bits(input int d);
        int p;
        p = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << p) < (d + p + 1)) begin
                p = p + 1;
            end
        end
        return p;
    endfunction

    localparam int PAR_BITS = calc_par_bits(DATA_BITS);
    localparam int CW_BITS  = DATA_BITS + PAR_BITS + 1;

    // XOR of the positions (1..CW_BITS-1) holding a one.
    function automatic logic [PAR_BITS-1:0] calc_syndrome(input logic [CW_BITS-1:0] cw);
        logic [PAR_BITS-1:0] s;
        s = '0;
        for (int j = 1; j < CW_BITS; j++) begin
            if (cw[j-1]) begin
                s = s ^ PAR_BITS'(j);
            end
        end
        return s;
    endfunction

    // Even parity over the whole codeword, including the overall bit.
    function automatic logic calc_parity(input logic [CW_BITS-1:0] cw);
        return ^cw;
    endfunction

    // Data sits at the non-power-of-two positions, lowest position first.
    function automatic logic [DATA_BITS-1:0] extract_data(input logic [CW_BITS-1:0] cw);
        logic [DATA_BITS-1:0] d;
        int                   k;
        d = '0;
        k = 0;
        for (int j = 1; j < CW_BITS; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[k] = cw[j-1];
                k    = k + 1;
            end
        end
        return d;
    endfunction

    logic                          advance_s;
    logic [NUM_CH*PAR_BITS-1:0]    syn_s;
    logic [NUM_CH-1:0]             par_s;
    logic [NUM_CH*DATA_BITS-1:0]   dout_s;
    logic [NUM_CH-1:0]             sbit_s;
    logic [NUM_CH-1:0]             dbit_s;
    logic [CW_BITS-1:0]            lane_cw_s;
    logic [PAR_BITS-1:0]           lane_syn_s;

    logic                          s1_valid_r;
    logic [NUM_CH*CW_BITS-1:0]     s1_cw_r;
    logic [NUM_CH*PAR_BITS-1:0]    s1_syn_r;
    logic [NUM_CH-1:0]             s1_par_r;
    logic                          o_valid_r;
    logic [NUM_CH*DATA_BITS-1:0]   dout_r;
    logic [NUM_CH-1:0]             sbit_r;
    logic [NUM_CH-1:0]             dbit_r;

    // The whole pipe moves together whenever the output slot is free or drained.
    assign advance_s      = !o_valid_r || bus.i_ready;
    assign bus.o_ready    = advance_s;
    assign bus.o_valid    = o_valid_r;
    assign bus.o_dout     = dout_r;
    assign bus.o_sbit_err = sbit_r;
    assign bus.o_dbit_err = dbit_r;

    // Syndrome and overall parity of each incoming lane.
    always_comb begin
        syn_s = '0;
        par_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            syn_s[c*PAR_BITS +: PAR_BITS] = calc_syndrome(bus.i_data[c*CW_BITS +: CW_BITS]);
            par_s[c]                      = calc_parity(bus.i_data[c*CW_BITS +: CW_BITS]);
        end
    end

    // Stage 1: codewords plus their check results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_cw_r    <= '0;
            s1_syn_r   <= '0;
            s1_par_r   <= '0;
        end else if (advance_s) begin
            s1_valid_r <= bus.i_valid;
            s1_cw_r    <= bus.i_data;
            s1_syn_r   <= syn_s;
            s1_par_r   <= par_s;
        end
    end

    // Per-lane correction and classification from the stage-1 results.
    always_comb begin
        dout_s     = '0;
        sbit_s     = '0;
        dbit_s     = '0;
        lane_cw_s  = '0;
        lane_syn_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lane_cw_s  = s1_cw_r[c*CW_BITS +: CW_BITS];
            lane_syn_s = s1_syn_r[c*PAR_BITS +: PAR_BITS];
            if (s1_par_r[c]) begin
                if (lane_syn_s == '0) begin
                    // Only the overall parity bit flipped; data is intact.
                    sbit_s[c] = 1'b1;
                end else if (int'(lane_syn_s) <= CW_BITS - 1) begin
                    lane_cw_s = lane_cw_s ^ (CW_BITS'(1'b1) << (int'(lane_syn_s) - 1));
                    sbit_s[c] = 1'b1;
                end else begin
                    // Syndrome points past the codeword: at least three bits bad.
                    dbit_s[c] = 1'b1;
                end
            end else begin
                if (lane_syn_s != '0) begin
                    dbit_s[c] = 1'b1;
                end else begin
                    sbit_s[c] = 1'b0;
                end
            end
            dout_s[c*DATA_BITS +: DATA_BITS] = extract_data(lane_cw_s);
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_r <= 1'b0;
            dout_r    <= '0;
            sbit_r    <= '0;
            dbit_r    <= '0;
        end else if (advance_s) begin
            o_valid_r <= s1_valid_r;
            dout_r    <= dout_s;
            sbit_r    <= sbit_s;
            dbit_r    <= dbit_s;
        end
    end

`ifdef HAM_ERR_CNT_EN
    function automatic logic [16:0] popcnt(input logic [NUM_CH-1:0] v);
        logic [16:0] n;
        n = 17'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + {16'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
        logic [16:0] s;
        s = {1'b0, a} + b;
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] sbit_cnt_r;
    logic [15:0] dbit_cnt_r;

    assign o_sbit_cnt = sbit_cnt_r;
    assign o_dbit_cnt = dbit_cnt_r;

    // Error counters, bumped on every output handshake; clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sbit_cnt_r <= 16'd0;
            dbit_cnt_r <= 16'd0;
        end else if (i_cnt_clr) begin
            sbit_cnt_r <= 16'd0;
            dbit_cnt_r <= 16'd0;
        end else if (o_valid_r && bus.i_ready) begin
            sbit_cnt_r <= sat_add(sbit_cnt_r, popcnt(sbit_r));
            dbit_cnt_r <= sat_add(dbit_cnt_r, popcnt(dbit_r));
        end
    end
`endif

endmodule

// File: tb/tb_ham_secded_dec_pipe.sv
// Testbench for ham_secded_dec_pipe at default parameters (4 data bits, 2 lanes).
module tb_ham_secded_dec_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ham_secded_dec_pipe_if #(.DATA_BITS(4), .NUM_CH(2)) bus ();

`ifdef HAM_ERR_CNT_EN
    logic        cnt_clr;
    logic [15:0] sbit_cnt;
    logic [15:0] dbit_cnt;
`endif

    ham_secded_dec_pipe #(.DATA_BITS(4), .NUM_CH(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
`ifdef HAM_ERR_CNT_EN
        .i_cnt_clr (cnt_clr),
        .o_sbit_cnt(sbit_cnt),
        .o_dbit_cnt(dbit_cnt),
`endif
        .bus       (bus)
    );

    int          checks = 0;
    int          fails  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] exp_next = 12'h000;
    logic [11:0] got;
    logic [11:0] want;
    logic [11:0] held;

    // Reference encoder: positions 1..7 = p1 p2 d0 p4 d1 d2 d3, position 8 overall parity.
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c    = 8'h00;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    function automatic logic [3:0] raw_data(input logic [7:0] c);
        return {c[6], c[5], c[4], c[2]};
    endfunction

    // Expected {dout, sbit, dbit} of one lane, from the number of flipped bits.
    function automatic logic [5:0] lane_exp(input logic [3:0] d, input logic [7:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return {d, 1'b0, 1'b0};
        else if (n == 1) return {d, 1'b1, 1'b0};
        else return {raw_data(enc(d) ^ m), 1'b0, 1'b1};
    endfunction

    function automatic logic [7:0] rand_mask();
        logic [7:0] m;
        int         a;
        int         b;
        int         k;
        m = 8'h00;
        k = $urandom_range(0, 2);
        a = $urandom_range(0, 7);
        b = (a + 1 + $urandom_range(0, 6)) % 8;
        if (k >= 1) m[a] = 1'b1;
        if (k == 2) m[b] = 1'b1;
        return m;
    endfunction

    // Scoreboard: expectations enter on input handshake, observations on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            obs_q.delete();
        end else begin
            if (bus.o_valid && bus.i_ready) obs_q.push_back({bus.o_dout, bus.o_sbit_err, bus.o_dbit_err});
            if (bus.i_valid && bus.o_ready) exp_q.push_back(exp_next);
        end
    end

    task automatic set_beat(input logic [3:0] d0, input logic [7:0] m0,
                            input logic [3:0] d1, input logic [7:0] m1);
        logic [5:0] l0;
        logic [5:0] l1;
        l0          = lane_exp(d0, m0);
        l1          = lane_exp(d1, m1);
        bus.i_valid = 1'b1;
        bus.i_data  = {enc(d1) ^ m1, enc(d0) ^ m0};
        exp_next    = {l1[5:2], l0[5:2], l1[1], l0[1], l1[0], l0[0]};
    endtask

    // Presents a beat and returns on the falling edge before the accepting edge.
    task automatic send_beat(input logic [3:0] d0, input logic [7:0] m0,
                             input logic [3:0] d1, input logic [7:0] m1);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        set_beat(d0, m0, d1, m1);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (bus.o_ready) acc = 1'b1;
        end
        checks++;
        if (!acc) begin
            fails++;
            $display("FAIL accept_timeout: o_ready stayed %b, required 1", bus.o_ready);
        end
    endtask

    task automatic idle_drain();
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_data  = 16'h0000;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
        if (bus.o_dout !== 8'h00) begin fails++; $display("FAIL reset_o_dout: got %h want 00", bus.o_dout); end
        if (bus.o_sbit_err !== 2'b00) begin fails++; $display("FAIL reset_sbit: got %b want 00", bus.o_sbit_err); end
        if (bus.o_dbit_err !== 2'b00) begin fails++; $display("FAIL reset_dbit: got %b want 00", bus.o_dbit_err); end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL reset_o_ready: got %b want 1", bus.o_ready); end
    endtask

    task automatic test_clean();
        send_beat(4'b1011, 8'h00, 4'b0110, 8'h00);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL clean_latency_early: o_valid %b want 0", bus.o_valid); end
        @(negedge clk);
        checks += 3;
        if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL clean_latency: o_valid %b want 1", bus.o_valid); end
        if (bus.o_dout[3:0] !== 4'b1011) begin fails++; $display("FAIL clean_lane0: got %b want 1011", bus.o_dout[3:0]); end
        if ({bus.o_sbit_err, bus.o_dbit_err} !== 4'b0000) begin
            fails++; $display("FAIL clean_flags: got %b want 0000", {bus.o_sbit_err, bus.o_dbit_err});
        end
        for (int i = 0; i < 16; i++) send_beat(4'(i), 8'h00, ~4'(i), 8'h00);
        idle_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL clean_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin fails++; $display("FAIL clean_beat: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_single();
        logic [7:0] m;
        // Lane1 position 5 flipped, then lane0 position 8 (overall parity) flipped.
        send_beat(4'b1011, 8'h00, 4'b1001, 8'h10);
        send_beat(4'b1011, 8'h80, 4'b0011, 8'h00);
        for (int p = 0; p < 8; p++) begin
            m = 8'h01 << p;
            send_beat(4'($urandom), m, 4'($urandom), 8'h00);
            send_beat(4'($urandom), 8'h00, 4'($urandom), m);
        end
        idle_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin fails++; $display("FAIL single_beat: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_double();
        // Lane0 positions 3 and 6, lane1 clean; then mixed double/single lanes.
        send_beat(4'b1011, 8'h24, 4'b0101, 8'h00);
        send_beat(4'b0111, 8'h81, 4'b1100, 8'h04);
        send_beat(4'b0000, 8'h03, 4'b1111, 8'h60);
        send_beat(4'b1010, 8'h40, 4'b0001, 8'h88);
        idle_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL double_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin fails++; $display("FAIL double_beat: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        send_beat(4'h1, 8'h00, 4'h2, 8'h00);
        send_beat(4'h3, 8'h02, 4'h4, 8'h00);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        set_beat(4'h5, 8'h00, 4'h6, 8'h20);
        held = {bus.o_dout, bus.o_sbit_err, bus.o_dbit_err};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks += 3;
            if (bus.o_ready !== 1'b0) begin fails++; $display("FAIL stall_o_ready: got %b want 0", bus.o_ready); end
            if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL stall_o_valid: got %b want 1", bus.o_valid); end
            if ({bus.o_dout, bus.o_sbit_err, bus.o_dbit_err} !== held) begin
                fails++; $display("FAIL stall_hold: got %h want %h", {bus.o_dout, bus.o_sbit_err, bus.o_dbit_err}, held);
            end
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL release_o_ready: got %b want 1", bus.o_ready); end
        send_beat(4'h7, 8'h00, 4'h8, 8'h00);
        idle_drain();
        checks++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            fails++; $display("FAIL bp_count: got %0d out %0d in, want 4 4", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin fails++; $display("FAIL bp_beat: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit acc_last;
        acc_last = 1'b1;
        for (int n = 0; n < 120; n++) begin
            @(posedge clk);
            #1;
            bus.i_ready = ($urandom_range(0, 3) != 0);
            if (!bus.i_valid || acc_last) begin
                if ($urandom_range(0, 3) == 0) bus.i_valid = 1'b0;
                else set_beat(4'($urandom), rand_mask(), 4'($urandom), rand_mask());
            end
            @(negedge clk);
            acc_last = bus.i_valid && bus.o_ready;
        end
        idle_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin fails++; $display("FAIL random_beat: got %h want %h", got, want); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        send_beat(4'h9, 8'h00, 4'hA, 8'h00);
        send_beat(4'hB, 8'h00, 4'hC, 8'h00);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL async_rst_o_valid: got %b want 0", bus.o_valid); end
        if (bus.o_dout !== 8'h00) begin fails++; $display("FAIL async_rst_o_dout: got %h want 00", bus.o_dout); end
        if ({bus.o_sbit_err, bus.o_dbit_err} !== 4'b0000) begin
            fails++; $display("FAIL async_rst_flags: got %b want 0000", {bus.o_sbit_err, bus.o_dbit_err});
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL post_rst_o_ready: got %b want 1", bus.o_ready); end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL stale_beat: o_valid %b want 0", bus.o_valid); end
        end
        checks++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL stale_count: got %0d want 0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

`ifdef HAM_ERR_CNT_EN
    task automatic test_err_cnt();
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        checks++;
        if (sbit_cnt !== 16'd0 || dbit_cnt !== 16'd0) begin fails++; $display("FAIL cnt_clr: got %0d %0d want 0 0", sbit_cnt, dbit_cnt); end
        for (int b = 0; b < 3; b++) send_beat(4'(b), 8'h04, 4'(b + 5), 8'h40);
        idle_drain();
        checks++;
        if (sbit_cnt !== 16'd6 || dbit_cnt !== 16'd0) begin fails++; $display("FAIL cnt_six: got %0d %0d want 6 0", sbit_cnt, dbit_cnt); end
        send_beat(4'h3, 8'h24, 4'h4, 8'h81);
        idle_drain();
        checks++;
        if (dbit_cnt !== 16'd2) begin fails++; $display("FAIL cnt_dbit: got %0d want 2", dbit_cnt); end
        @(posedge clk); #1;
        set_beat(4'h1, 8'h02, 4'h2, 8'h10);
        repeat (32770) @(posedge clk);
        #1;
        checks++;
        if (sbit_cnt !== 16'hFFFF) begin fails++; $display("FAIL cnt_saturate: got %h want FFFF", sbit_cnt); end
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if (sbit_cnt !== 16'd0 || dbit_cnt !== 16'd0) begin fails++; $display("FAIL cnt_clr_override: got %0d %0d want 0 0", sbit_cnt, dbit_cnt); end
        idle_drain();
        obs_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef HAM_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_backpressure();
        test_random();
        test_reset_midflight();
`ifdef HAM_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
